// File: rtl/hd44780_responder.sv
// HD44780-compatible display-side responder: syncs the host E/RS/RW/DATA bus, decodes
// instructions into an 80-byte DDRAM and AC. Host readback enabled by defining LCD_READBACK_EN.
module hd44780_responder #(
   parameter int unsigned EXEC_SHORT = 2000,
   parameter int unsigned EXEC_LONG  = 82000,
   parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data_i,
   output logic [7:0] lcd_data_o,
   output logic       lcd_data_oe,
   input  logic [6:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [6:0] cursor_addr,
   output logic       busy,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       cfg_8bit,
   output logic       cfg_2line,
   output logic [5:0] disp_shift,
   output logic       wr_strobe,
   output logic       protocol_err
);

   localparam logic [1:0] ST_FILL = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_EXEC = 2'd2;

   localparam int unsigned CNT_MAX = (EXEC_LONG > EXEC_SHORT) ? EXEC_LONG : EXEC_SHORT;
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(EXEC_SHORT);
   localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(EXEC_LONG);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [6:0] LAST_IDX  = 7'd79;
   localparam logic [6:0] RAM_DEPTH = 7'd80;

`ifdef LCD_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   // Bus protocol: the host holds RS/RW/DATA stable around E; a transaction is accepted
   // only on the synchronised falling edge of E, using the bus values sampled just before it.
   logic [1:0] e_sync, rs_sync, rw_sync;
   logic [7:0] data_s1, data_s2;
   logic       e_q, rs_q, rw_q;
   logic [7:0] data_q;
   logic       strobe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_sync  <= '0;
         rs_sync <= '0;
         rw_sync <= '0;
         data_s1 <= '0;
         data_s2 <= '0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         rw_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         e_sync  <= {e_sync[0], lcd_e};
         rs_sync <= {rs_sync[0], lcd_rs};
         rw_sync <= {rw_sync[0], lcd_rw};
         data_s1 <= lcd_data_i;
         data_s2 <= data_s1;
         e_q     <= e_sync[1];
         rs_q    <= rs_sync[1];
         rw_q    <= rw_sync[1];
         data_q  <= data_s2;
      end
   end

   assign strobe = e_q & ~e_sync[1];

   // AC stepping: DDRAM lines are 0x00-0x27 and 0x40-0x67, CGRAM wraps at 64.
   function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up, input logic cg);
      if (cg)
         return {1'b0, up ? (a[5:0] + 6'd1) : (a[5:0] - 6'd1)};
      if (up)
         return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
   endfunction

   function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
      if (up)
         return (s == 6'd39) ? 6'd0 : s + 6'd1;
      return (s == 6'd0) ? 6'd39 : s - 6'd1;
   endfunction

   function automatic logic [6:0] map_ac(input logic [6:0] a);
      return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
   endfunction

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [6:0]       fill_idx;
   logic [6:0]       ac;
   logic             inc_dec;
   logic             shift_en;
   logic             cgram_mode;

   logic [7:0] ddram [0:79];
   logic       data_wr, mem_we, strobe_err;
   logic [6:0] ac_idx, mem_waddr;
   logic [7:0] mem_wdata;

   assign busy        = (state != ST_IDLE);
   assign cursor_addr = ac;
   assign ac_idx      = map_ac(ac);
   assign data_wr     = strobe && (state == ST_IDLE) && rs_q && !rw_q && !cgram_mode
                        && (ac_idx < RAM_DEPTH);

   // A status read (RS=0, RW=1) is the one transaction legal while busy, and only with readback.
   assign strobe_err = strobe && (READBACK ? ((state != ST_IDLE) && !(rw_q && !rs_q))
                                           : ((state != ST_IDLE) || rw_q));

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = fill_idx;
      mem_wdata = FILL_CHAR;
      if (state == ST_FILL) begin
         mem_we = 1'b1;
      end else if (data_wr) begin
         mem_we    = 1'b1;
         mem_waddr = ac_idx;
         mem_wdata = data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         ddram[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else
         rd_data <= (rd_addr < RAM_DEPTH) ? ddram[rd_addr] : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_FILL;
         cnt          <= '0;
         fill_idx     <= '0;
         ac           <= '0;
         inc_dec      <= 1'b1;
         shift_en     <= 1'b0;
         cgram_mode   <= 1'b0;
         disp_on      <= 1'b0;
         cursor_on    <= 1'b0;
         blink_on     <= 1'b0;
         cfg_8bit     <= 1'b0;
         cfg_2line    <= 1'b0;
         disp_shift   <= '0;
         wr_strobe    <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         wr_strobe <= data_wr;
         if (strobe_err)
            protocol_err <= 1'b1;
         case (state)
            ST_FILL: begin
               // The Clear busy time keeps counting while the fill runs.
               fill_idx <= fill_idx + 7'd1;
               if (cnt != '0)
                  cnt <= cnt - CNT_ONE;
               if (fill_idx == LAST_IDX) begin
                  fill_idx <= '0;
                  state    <= (cnt > CNT_ONE) ? ST_EXEC : ST_IDLE;
               end
            end
            ST_EXEC: begin
               cnt <= cnt - CNT_ONE;
               if (cnt <= CNT_ONE) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (strobe && !rw_q) begin
                  state <= ST_EXEC;
                  cnt   <= CNT_SHORT;
                  if (rs_q) begin
                     ac <= ac_step(ac, inc_dec, cgram_mode);
                     if (shift_en)
                        disp_shift <= shift_step(disp_shift, inc_dec);
                  end else begin
                     casez (data_q)
                        8'b1???????: begin
                           if (data_q[5:0] >= 6'h28) begin
                              protocol_err <= 1'b1;
                           end else begin
                              ac         <= data_q[6:0];
                              cgram_mode <= 1'b0;
                           end
                        end
                        8'b01??????: begin
                           cgram_mode <= 1'b1;
                           ac         <= {1'b0, data_q[5:0]};
                        end
                        8'b001?????: begin
                           cfg_8bit  <= data_q[4];
                           cfg_2line <= data_q[3];
                        end
                        8'b0001????: begin
                           if (data_q[3])
                              disp_shift <= shift_step(disp_shift, data_q[2]);
                           else
                              ac <= ac_step(ac, data_q[2], cgram_mode);
                        end
                        8'b00001???: begin
                           disp_on   <= data_q[2];
                           cursor_on <= data_q[1];
                           blink_on  <= data_q[0];
                        end
                        8'b000001??: begin
                           inc_dec  <= data_q[1];
                           shift_en <= data_q[0];
                        end
                        8'b0000001?: begin
                           ac         <= '0;
                           disp_shift <= '0;
                           cnt        <= CNT_LONG;
                        end
                        8'b00000001: begin
                           ac         <= '0;
                           inc_dec    <= 1'b1;
                           disp_shift <= '0;
                           cnt        <= CNT_LONG;
                           fill_idx   <= '0;
                           state      <= ST_FILL;
                        end
                        default: ;
                     endcase
                  end
               end else if (strobe && READBACK && rs_q) begin
                  state <= ST_EXEC;
                  cnt   <= CNT_SHORT;
                  ac    <= ac_step(ac, inc_dec, cgram_mode);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef LCD_READBACK_EN
   // Drive window follows synced E, so the driver releases one cycle after E falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcd_data_oe <= 1'b0;
         lcd_data_o  <= '0;
      end else begin
         lcd_data_oe <= e_sync[1] & rw_sync[1];
         if (e_sync[1] && rw_sync[1]) begin
            if (rs_sync[1])
               lcd_data_o <= (ac_idx < RAM_DEPTH) ? ddram[ac_idx] : 8'h00;
            else
               lcd_data_o <= {busy, ac};
         end else begin
            lcd_data_o <= '0;
         end
      end
   end
`else
   assign lcd_data_oe = 1'b0;
   assign lcd_data_o  = '0;
`endif

endmodule
